// File: rtl/ps2_pkg.sv
// Shared constants, frame FSM state type and byte-classification helpers
// for the PS/2 keyboard event decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT     = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK     = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE   = 8'hE1;
  localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

  // Bytes that follow E1 in the Pause make sequence and must be swallowed.
  localparam logic [2:0] PS2_PAUSE_TAIL  = 3'd7;

  localparam int EV_TOGGLE  = 10;
  localparam int EV_PRESSED = 9;
  localparam int EV_EXT     = 8;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

  // Keyboard status/ack bytes that never carry a key event.
  function automatic logic is_dropped(input logic [7:0] code);
    case (code)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] code);
    return (code == PS2_FAKE_LSHIFT) || (code == PS2_FAKE_RSHIFT);
  endfunction

  function automatic logic [10:0] ev_word(input logic toggle, input logic pressed,
                                          input logic ext, input logic [7:0] code);
    logic [10:0] w;
    w             = {3'b000, code};
    w[EV_TOGGLE]  = toggle;
    w[EV_PRESSED] = pressed;
    w[EV_EXT]     = ext;
    return w;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: line synchronizers, falling-edge detect,
// start/data/parity/stop FSM and an inter-edge watchdog.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT     = 4096,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int             CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  WD_LAST = CW'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  frame_state_t           state;
  logic [2:0]             bitcnt;
  logic [7:0]             shift;
  logic                   parity_bit;
  logic [CW-1:0]          wd_cnt;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  // byte_valid is a one-ce-cycle strobe with rx_byte stable alongside it;
  // there is no ready, so the consumer must take every strobe it sees.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync   <= '1;
      data_sync  <= '1;
      clk_prev   <= 1'b1;
      state      <= IDLE;
      bitcnt     <= 3'd0;
      shift      <= 8'h00;
      parity_bit <= 1'b0;
      wd_cnt     <= '0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else if (ce) begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev   <= clk_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || fall) wd_cnt <= '0;
      else                       wd_cnt <= wd_cnt + CW'(1);

      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_s) begin
              state  <= DATA;
              bitcnt <= 3'd0;
            end
          end
          DATA: begin
            shift <= {data_s, shift[7:1]};
            if (bitcnt == 3'd7) state <= PARITY;
            else                bitcnt <= bitcnt + 3'd1;
          end
          PARITY: begin
            parity_bit <= data_s;
            state      <= STOP;
          end
          STOP: begin
            if (data_s && (^{shift, parity_bit})) begin
              rx_byte    <= shift;
              byte_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && wd_cnt == WD_LAST) begin
        // Device stopped clocking mid-frame: abandon it.
        state     <= IDLE;
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_event_decoder.sv
// PS/2 scan-set-2 byte stream to 11-bit key-event word {toggle, pressed, ext, code}.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of the held key.
module ps2_event_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT     = 4096,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2,
  output logic        frame_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       ext_flag;
  logic       brk_flag;
  logic [2:0] discard_cnt;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       last_valid;
  logic [8:0] last_make;
`endif

  ps2_rx_frame #(
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .ce         (ce),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps2         <= 11'h000;
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      discard_cnt <= 3'd0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      last_valid  <= 1'b0;
      last_make   <= 9'h000;
`endif
    end else if (ce && byte_valid) begin
      if (discard_cnt != 3'd0) begin
        discard_cnt <= discard_cnt - 3'd1;
      end else if (rx_byte == PS2_PFX_PAUSE) begin
        discard_cnt <= PS2_PAUSE_TAIL;
      end else if (rx_byte == PS2_PFX_EXT) begin
        ext_flag <= 1'b1;
      end else if (rx_byte == PS2_PFX_BRK) begin
        brk_flag <= 1'b1;
      end else if (is_dropped(rx_byte)) begin
        // Status bytes leave any pending prefix intact.
      end else if (ext_flag && is_fake_shift(rx_byte)) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (!brk_flag && last_valid && last_make == {ext_flag, rx_byte}) begin
          // Auto-repeat of the held key: no new event.
        end else begin
          ps2 <= ev_word(~ps2[EV_TOGGLE], ~brk_flag, ext_flag, rx_byte);
          if (!brk_flag) begin
            last_valid <= 1'b1;
            last_make  <= {ext_flag, rx_byte};
          end else if (last_valid && last_make == {ext_flag, rx_byte}) begin
            last_valid <= 1'b0;
          end
        end
`else
        ps2 <= ev_word(~ps2[EV_TOGGLE], ~brk_flag, ext_flag, rx_byte);
`endif
      end
    end
  end

endmodule

// File: tb/tb_ps2_event_decoder.sv
// Self-checking bench for ps2_event_decoder: drives PS/2 frames, scoreboards
// the event words and counts frame_err pulses.
module tb_ps2_event_decoder;

  localparam int TIMEOUT     = 4096;
  localparam int SYNC_STAGES = 2;

  logic        clock;
  logic        reset;
  logic        ce;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2;
  logic        frame_err;

  logic [10:0] exp_q[$];
  logic        exp_toggle;
  logic [10:0] prev_ps2;
  int          compared   = 0;
  int          mismatched = 0;
  int          ev_seen    = 0;
  int          err_cycles = 0;
  int          half       = 6;

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic        lm_valid;
  logic [8:0]  lm;
`endif

  ps2_event_decoder #(
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ce        (ce),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2       (ps2),
    .frame_err (frame_err)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "global timeout");
  end

  // Scoreboard monitor: every change of the event word pops one expectation.
  always @(negedge clock) begin
    logic [10:0] exp;
    if (reset) begin
      prev_ps2 = ps2;
    end else begin
      if (ce && frame_err) err_cycles++;
      if (ps2 !== prev_ps2) begin
        ev_seen++;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL event_unexpected: got %h, required no event", ps2);
        end else begin
          exp = exp_q.pop_front();
          if (ps2 !== exp) begin
            mismatched++;
            $display("FAIL event_word: got %h, required %h", ps2, exp);
          end
        end
        prev_ps2 = ps2;
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    reset    = 1'b1;
    ce       = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clock);
    reset      = 1'b0;
    exp_toggle = 1'b0;
    exp_q.delete();
`ifdef PS2_TYPEMATIC_FILTER_EN
    lm_valid = 1'b0;
    lm       = 9'h000;
`endif
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (half) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (half) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(bad_par ? (^b) : ~(^b));
    send_bit(stop);
    ps2_data = 1'b1;
  endtask

  task automatic expect_key(input logic pressed, input logic ext, input logic [7:0] code);
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (pressed && lm_valid && lm == {ext, code}) return;
    if (pressed) begin
      lm_valid = 1'b1;
      lm       = {ext, code};
    end else if (lm_valid && lm == {ext, code}) begin
      lm_valid = 1'b0;
    end
`endif
    exp_toggle = ~exp_toggle;
    exp_q.push_back({exp_toggle, pressed, ext, code});
  endtask

  task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
    expect_key(pressed, ext, code);
    if (ext)      send_frame(8'hE0, 1'b0, 1'b1);
    if (!pressed) send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(code, 1'b0, 1'b1);
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (2) @(negedge clock);
    compared++;
    if (ps2 !== 11'h000 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: ps2=%h err=%b, required 000/0", ps2, frame_err);
    end
    do_reset();
    repeat (6) @(negedge clock);
    compared++;
    if (ps2 !== 11'h000 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: ps2=%h err=%b, required 000/0", ps2, frame_err);
    end
  endtask

  task automatic test_single_make();
    logic [7:0] b;
    b = 8'h1C;
    expect_key(1'b1, 1'b0, b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b));
    ps2_data = 1'b1;
    repeat (half) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (SYNC_STAGES + 1) @(negedge clock);
    compared++;
    if (ps2 !== 11'h000) begin
      mismatched++;
      $display("FAIL latency_early: ps2=%h, required 000", ps2);
    end
    @(negedge clock);
    compared++;
    if (ps2 !== 11'h61C) begin
      mismatched++;
      $display("FAIL latency_word: ps2=%h, required 61c", ps2);
    end
    repeat (half - SYNC_STAGES - 2) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic test_break();
    int e0;
    e0 = err_cycles;
    send_frame(8'hF0, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    compared++;
    if (ps2 !== 11'h61C) begin
      mismatched++;
      $display("FAIL break_prefix_hold: ps2=%h, required 61c", ps2);
    end
    expect_key(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    compared++;
    if (ps2 !== 11'h01C) begin
      mismatched++;
      $display("FAIL break_word: ps2=%h, required 01c", ps2);
    end
    compared++;
    if (err_cycles - e0 != 0 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL break_clean: err=%0d pending=%0d, required 0/0", err_cycles - e0, exp_q.size());
    end
  endtask

  task automatic test_extended();
    key(1'b1, 1'b1, 8'h75);
    repeat (4) @(negedge clock);
    compared++;
    if (ps2 !== 11'h775) begin
      mismatched++;
      $display("FAIL ext_make: ps2=%h, required 775", ps2);
    end
    key(1'b0, 1'b1, 8'h75);
    repeat (4) @(negedge clock);
    compared++;
    if (ps2 !== 11'h175) begin
      mismatched++;
      $display("FAIL ext_break: ps2=%h, required 175", ps2);
    end
  endtask

  task automatic test_frame_errors();
    int e0;
    int n;
    logic [10:0] w;
    w  = ps2;
    e0 = err_cycles;
    send_frame(8'h1C, 1'b1, 1'b1);
    repeat (4) @(negedge clock);
    compared++;
    if (err_cycles - e0 != 1 || ps2 !== w) begin
      mismatched++;
      $display("FAIL parity_err: pulses=%0d ps2=%h, required 1/%h", err_cycles - e0, ps2, w);
    end
    e0 = err_cycles;
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    compared++;
    if (err_cycles - e0 != 1 || ps2 !== w) begin
      mismatched++;
      $display("FAIL stop_err: pulses=%0d ps2=%h, required 1/%h", err_cycles - e0, ps2, w);
    end
    e0 = err_cycles;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    n = 0;
    while (frame_err !== 1'b1 && n < TIMEOUT + 64) begin
      @(negedge clock);
      n++;
    end
    compared++;
    if (n < TIMEOUT - half || n > TIMEOUT + 4) begin
      mismatched++;
      $display("FAIL timeout_fire: fired after %0d cycles, required about %0d", n, TIMEOUT);
    end
    repeat (4) @(negedge clock);
    compared++;
    if (err_cycles - e0 != 1 || ps2 !== w) begin
      mismatched++;
      $display("FAIL timeout_pulse: pulses=%0d ps2=%h, required 1/%h", err_cycles - e0, ps2, w);
    end
    key(1'b1, 1'b0, 8'h1C);
    repeat (8) @(negedge clock);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL after_timeout: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_pause_fake_shift();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send_frame(seq[i], 1'b0, 1'b1);
    key(1'b1, 1'b0, 8'h4D);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h59, 1'b0, 1'b1);
    key(1'b1, 1'b0, 8'h32);
    expect_key(1'b0, 1'b0, 8'h33);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    send_frame(8'h33, 1'b0, 1'b1);
    repeat (8) @(negedge clock);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL pause_fake_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    key(1'b1, 1'b0, 8'h1B);
    key(1'b1, 1'b1, 8'h1D);
    key(1'b0, 1'b0, 8'h1B);
    key(1'b0, 1'b1, 8'h1D);
    repeat (8) @(negedge clock);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL back_to_back_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_clk = 1'b0;
    @(negedge clock);
    e0 = err_cycles;
    reset = 1'b1;
    @(negedge clock);
    compared++;
    if (ps2 !== 11'h000 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_frame: ps2=%h err=%b, required 000/0", ps2, frame_err);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    do_reset();
    expect_key(1'b1, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    compared++;
    if (ps2 !== 11'h61C || err_cycles != e0) begin
      mismatched++;
      $display("FAIL reset_prefix_lost: ps2=%h errs=%0d, required 61c/0", ps2, err_cycles - e0);
    end
  endtask

  task automatic test_ce_gating();
    bit done;
    done = 1'b0;
    half = 16;
    fork
      begin
        key(1'b1, 1'b0, 8'h2D);
        key(1'b0, 1'b0, 8'h2D);
        done = 1'b1;
      end
      begin
        int c;
        c = 0;
        while (!done) begin
          @(negedge clock);
          c++;
          ce = (c % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        ce = 1'b1;
      end
    join
    half = 6;
    repeat (8) @(negedge clock);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL ce_gating_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_random_keys();
    logic [7:0] code_tab [12];
    code_tab = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
                 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h3A};
    for (int i = 0; i < 10; i++) begin
      key(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          code_tab[$urandom_range(0, 11)]);
    end
    repeat (8) @(negedge clock);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL random_drain: pending=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_typematic();
    int ev0;
    int want;
    do_reset();
    ev0 = ev_seen;
`ifdef PS2_TYPEMATIC_FILTER_EN
    want = 2;
`else
    want = 4;
`endif
    key(1'b1, 1'b0, 8'h1C);
    key(1'b1, 1'b0, 8'h1C);
    key(1'b1, 1'b0, 8'h1C);
    key(1'b0, 1'b0, 8'h1C);
    repeat (8) @(negedge clock);
    compared++;
    if (ev_seen - ev0 != want || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL typematic_toggles: got %0d pending %0d, required %0d/0",
               ev_seen - ev0, exp_q.size(), want);
    end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_break();
    test_extended();
    test_frame_errors();
    test_pause_fake_shift();
    test_back_to_back();
    test_reset_mid_frame();
    test_ce_gating();
    test_random_keys();
    test_typematic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
